// File: rtl/fdtd_update_engine.sv
// Three-stage FDTD field update datapath: HY/EZ leapfrog update, soft source injection
// and pass-through, all lanes sharing one stall-able pipeline with sweep beat tracking.
module fdtd_update_engine #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int FRAC_BITS       = 16,
  parameter int NUM_LANES       = 2,
  parameter int NUM_BEATS       = 64
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [1:0]                           mode_i,
  input  logic [FDTD_DATA_WIDTH-1:0]           c0_i,
  input  logic [FDTD_DATA_WIDTH-1:0]           c1_i,
  input  logic [NUM_LANES*FDTD_DATA_WIDTH-1:0] f0_i,
  input  logic [NUM_LANES*FDTD_DATA_WIDTH-1:0] f1_i,
  input  logic [NUM_LANES*FDTD_DATA_WIDTH-1:0] f2_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [NUM_LANES*FDTD_DATA_WIDTH-1:0] res_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 out_last_o,
  output logic                                 sat_o,
  input  logic                                 clr_sat_i,
  output logic [$clog2(NUM_BEATS)-1:0]         beat_cnt_o
);

  localparam int W  = FDTD_DATA_WIDTH;
  localparam int L  = NUM_LANES;
  localparam int CW = $clog2(NUM_BEATS);
  localparam int PW = 2*W + 2;
  localparam int SW = 2*W + 3;

  typedef enum logic [1:0] {
    MODE_HY   = 2'd0,
    MODE_EZ   = 2'd1,
    MODE_SRC  = 2'd2,
    MODE_PASS = 2'd3
  } mode_t;

  logic en;
  logic accept;
  logic last_beat;

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;
  assign accept     = in_valid_i && en;
  assign last_beat  = (beat_cnt_o == CW'(NUM_BEATS - 1));

  logic           s1_valid, s1_last;
  mode_t          s1_mode;
  logic [W-1:0]   s1_c0, s1_c1;
  logic [W-1:0]   s1_f0 [L];
  logic [W:0]     s1_b  [L];
  logic [W:0]     b_next [L];

  logic           s2_valid, s2_last;
  mode_t          s2_mode;
  logic [W-1:0]   s2_f0 [L];
  logic [PW-1:0]  s2_p0 [L];
  logic [PW-1:0]  s2_p1 [L];

  logic signed [SW-1:0] wide [L];
  logic [W-1:0]   lane_res [L];
  logic [L-1:0]   lane_clamp;
  logic           sat_set;

  // Source injection scales f1 alone, so the coupling operand skips the subtraction there
  always_comb begin
    for (int k = 0; k < L; k++) begin
      b_next[k] = {f1_i[k*W+W-1], f1_i[k*W +: W]};
      if (mode_t'(mode_i) != MODE_SRC)
        b_next[k] = b_next[k] - {f2_i[k*W+W-1], f2_i[k*W +: W]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      beat_cnt_o <= '0;
    end else if (en) begin
      s1_valid <= in_valid_i;
      s1_last  <= accept && last_beat;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (accept)
        beat_cnt_o <= last_beat ? '0 : beat_cnt_o + CW'(1);
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them
  always_ff @(posedge CLK) begin
    if (en) begin
      s1_mode <= mode_t'(mode_i);
      s1_c0   <= c0_i;
      s1_c1   <= c1_i;
      s2_mode <= s1_mode;
      for (int k = 0; k < L; k++) begin
        s1_f0[k] <= f0_i[k*W +: W];
        s1_b[k]  <= b_next[k];
        s2_f0[k] <= s1_f0[k];
        s2_p0[k] <= {{(PW-W){s1_c0[W-1]}}, s1_c0} * {{(PW-W){s1_f0[k][W-1]}}, s1_f0[k]};
        s2_p1[k] <= {{(PW-W){s1_c1[W-1]}}, s1_c1} * {{(PW-W-1){s1_b[k][W]}}, s1_b[k]};
      end
    end
  end

  // A result fits in W bits only when its upper bits are pure sign extension
  always_comb begin
    lane_clamp = '0;
    for (int k = 0; k < L; k++) begin
      case (s2_mode)
        MODE_HY, MODE_EZ:
          wide[k] = $signed({s2_p0[k][PW-1], s2_p0[k]} + {s2_p1[k][PW-1], s2_p1[k]}) >>> FRAC_BITS;
        MODE_SRC:
          wide[k] = $signed({{(SW-W){s2_f0[k][W-1]}}, s2_f0[k]})
                  + ($signed({s2_p1[k][PW-1], s2_p1[k]}) >>> FRAC_BITS);
        default:
          wide[k] = $signed({{(SW-W){s2_f0[k][W-1]}}, s2_f0[k]});
      endcase
      if ((&wide[k][SW-1:W-1]) || !(|wide[k][SW-1:W-1])) begin
        lane_res[k] = wide[k][W-1:0];
      end else begin
        lane_clamp[k] = 1'b1;
        lane_res[k]   = wide[k][SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end
  end

  assign sat_set = en && s2_valid && (|lane_clamp);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      res_o       <= '0;
      sat_o       <= 1'b0;
    end else begin
      if (en) begin
        out_valid_o <= s2_valid;
        out_last_o  <= s2_valid && s2_last;
        if (s2_valid)
          for (int k = 0; k < L; k++)
            res_o[k*W +: W] <= lane_res[k];
      end
      sat_o <= (sat_o && !clr_sat_i) || sat_set;
    end
  end

endmodule

// File: tb/tb_fdtd_update_engine.sv
// Scoreboard bench for fdtd_update_engine: a wide-integer reference model predicts each
// accepted beat, and a negedge monitor compares outputs, last flags, latency and beat count.
module tb_fdtd_update_engine;

  logic        CLK;
  logic        RST;
  logic [1:0]  mode_i;
  logic [31:0] c0_i, c1_i;
  logic [63:0] f0_i, f1_i, f2_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] res_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic        sat_o;
  logic        clr_sat_i;
  logic [1:0]  beat_cnt_o;

  typedef struct {
    logic [63:0] res;
    logic        last;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          tb_cnt = 0;
  int          lasts_seen = 0;
  bit          mon_en = 0;
  bit          rand_ready = 0;
  logic [63:0] last_res = '0;

  fdtd_update_engine #(
    .FDTD_DATA_WIDTH(32),
    .FRAC_BITS(16),
    .NUM_LANES(2),
    .NUM_BEATS(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .mode_i(mode_i),
    .c0_i(c0_i),
    .c1_i(c1_i),
    .f0_i(f0_i),
    .f1_i(f1_i),
    .f2_i(f2_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .res_o(res_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_last_o(out_last_o),
    .sat_o(sat_o),
    .clr_sat_i(clr_sat_i),
    .beat_cnt_o(beat_cnt_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  function automatic logic [31:0] laneModel(input logic [1:0] m, input logic [31:0] c0,
                                            input logic [31:0] c1, input logic [31:0] f0,
                                            input logic [31:0] f1, input logic [31:0] f2);
    logic signed [127:0] s;
    case (m)
      2'd0, 2'd1: s = (sx(c0) * sx(f0) + sx(c1) * (sx(f1) - sx(f2))) >>> 16;
      2'd2:       s = sx(f0) + ((sx(c1) * sx(f1)) >>> 16);
      default:    s = sx(f0);
    endcase
    if (s > 128'sd2147483647) return 32'h7FFFFFFF;
    if (s < -128'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  // Inputs and outputs are sampled at the negedge, i.e. what the next rising edge will see
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      checkOutput("beat_cnt", 64'(beat_cnt_o), 64'(tb_cnt));
      if (RST) begin
        sb.delete();
        tb_cnt = 0;
      end else begin
        if (out_valid_o) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_out", 64'(out_valid_o), 64'(0));
          end else begin
            e = sb[0];
            checkOutput("res", res_o, e.res);
            checkOutput("last", 64'(out_last_o), 64'(e.last));
            if (out_ready_i) begin
              if (e.chk_lat) checkOutput("latency", 64'(cyc - e.cyc), 64'(3));
              if (out_last_o) lasts_seen++;
              last_res = res_o;
              void'(sb.pop_front());
            end
          end
        end
        if (in_valid_i && in_ready_o) begin
          e.res  = {laneModel(mode_i, c0_i, c1_i, f0_i[63:32], f1_i[63:32], f2_i[63:32]),
                    laneModel(mode_i, c0_i, c1_i, f0_i[31:0], f1_i[31:0], f2_i[31:0])};
          e.last = (tb_cnt == 3);
          e.cyc  = cyc;
          e.chk_lat = !rand_ready;
          sb.push_back(e);
          tb_cnt = (tb_cnt + 1) % 4;
        end
      end
    end
  end

  task automatic stepCycle(output bit acc);
    @(negedge CLK);
    acc = in_valid_i && in_ready_o && !RST;
    @(posedge CLK);
    #1;
    if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] c0, input logic [31:0] c1,
                               input logic [63:0] f0, input logic [63:0] f1, input logic [63:0] f2);
    bit acc;
    mode_i = m;
    c0_i = c0;
    c1_i = c1;
    f0_i = f0;
    f1_i = f1;
    f2_i = f2;
    in_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) stepCycle(acc);
    if (!acc) checkOutput("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drainPipe();
    bit acc;
    in_valid_i = 1'b0;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid_o); i++) stepCycle(acc);
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [31:0] smallRand();
    return 32'($urandom_range(0, 400000)) - 32'd200000;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    RST = 1'b1;
    mode_i = 2'd0;
    c0_i = '0;
    c1_i = '0;
    f0_i = '0;
    f1_i = '0;
    f2_i = '0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    clr_sat_i = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid_o), 64'(0));
    checkOutput("rst_out_last", 64'(out_last_o), 64'(0));
    checkOutput("rst_sat", 64'(sat_o), 64'(0));
    checkOutput("rst_beat_cnt", 64'(beat_cnt_o), 64'(0));
    checkOutput("rst_res", res_o, 64'(0));
    RST = 1'b0;
    mon_en = 1'b1;

    applyStimulus(2'd0, 32'd65536, 32'd32768, {2{32'd131072}}, {2{32'd196608}}, {2{32'd65536}});
    drainPipe();
    checkOutput("hy_ref", last_res, {32'd196608, 32'd196608});
    checkOutput("hy_no_sat", 64'(sat_o), 64'(0));

    applyStimulus(2'd2, 32'd0, 32'd131072, {2{32'd65536}}, {2{32'd32768}}, 64'(0));
    drainPipe();
    checkOutput("src_ref", last_res, {32'd131072, 32'd131072});

    applyStimulus(2'd1, 32'h7FFFFFFF, 32'd0, {2{32'h7FFFFFFF}}, 64'(0), 64'(0));
    drainPipe();
    checkOutput("ez_clamp", last_res, {32'h7FFFFFFF, 32'h7FFFFFFF});
    checkOutput("sat_set", 64'(sat_o), 64'(1));
    repeat (3) stepCycle(acc);
    checkOutput("sat_sticky", 64'(sat_o), 64'(1));
    clr_sat_i = 1'b1;
    stepCycle(acc);
    clr_sat_i = 1'b0;
    checkOutput("sat_clr", 64'(sat_o), 64'(0));

    for (int i = 0; i < 5; i++)
      applyStimulus(2'(i % 3), smallRand() + 32'd65536, smallRand(),
                    {smallRand(), smallRand()}, {smallRand(), smallRand()},
                    {smallRand(), smallRand()});
    drainPipe();

    lasts_seen = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom,
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    drainPipe();
    rand_ready = 1'b0;
    out_ready_i = 1'b1;
    stepCycle(acc);
    checkOutput("stream_lasts", 64'(lasts_seen), 64'(2));
    checkOutput("stream_wrap", 64'(beat_cnt_o), 64'(0));

    clr_sat_i = 1'b1;
    stepCycle(acc);
    applyStimulus(2'd1, 32'h7FFFFFFF, 32'd0, {2{32'h7FFFFFFF}}, 64'(0), 64'(0));
    in_valid_i = 1'b0;
    repeat (2) stepCycle(acc);
    checkOutput("sat_clr_and_set", 64'(sat_o), 64'(1));
    clr_sat_i = 1'b0;
    drainPipe();

    applyStimulus(2'd0, 32'd65536, 32'd65536, {2{32'd1000}}, {2{32'd3000}}, {2{32'd500}});
    applyStimulus(2'd2, 32'd0, 32'd65536, {2{32'd7}}, {2{32'd9}}, 64'(0));
    in_valid_i = 1'b0;
    RST = 1'b1;
    stepCycle(acc);
    RST = 1'b0;
    checkOutput("rst2_out_valid", 64'(out_valid_o), 64'(0));
    checkOutput("rst2_beat_cnt", 64'(beat_cnt_o), 64'(0));
    checkOutput("rst2_sat", 64'(sat_o), 64'(0));
    checkOutput("rst2_in_ready", 64'(in_ready_o), 64'(1));
    repeat (6) stepCycle(acc);
    applyStimulus(2'd0, 32'd65536, 32'd32768, {2{32'd131072}}, {2{32'd196608}}, {2{32'd65536}});
    drainPipe();
    checkOutput("post_rst_ref", last_res, {32'd196608, 32'd196608});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
